// File: rtl/fifo_rd_fwft.sv
// ---------------------------------------------------------------------------
// fifo_rd_fwft
//   Read-domain output stage of the async FIFO. Turns the standard read port
//   (rd-enable, registered empty, RAM data RL cycles later) into a
//   first-word-fall-through valid/ready stream. Words are prefetched into a
//   small circular skid buffer so the stream runs at full rate under
//   consumer backpressure. Everything runs on I_RD_CLK.
//
// Ports
//   I_RD_CLK    in   read clock
//   I_RD_RST_N  in   asynchronous active-low reset
//   I_RD_EMPTY  in   registered FIFO empty from the read-pointer logic
//   O_RD_EN     out  pop one word from the FIFO (advances read pointer)
//   I_RD_DATA   in   RAM read data, valid RL cycles after O_RD_EN
//   I_RD_FLUSH  in   sync flush: drop buffered and in-flight words
//   O_M_VALID   out  stream word valid
//   I_M_READY   in   consumer accepts word
//   O_M_DATA    out  stream data (buffer head)
//   O_M_LEVEL   out  number of buffered words
// ---------------------------------------------------------------------------
module fifo_rd_fwft #(
    parameter  int DW    = 8,
    parameter  int RL    = 1,
    parameter  int BUF_D = 2,
    localparam int LW    = $clog2(BUF_D + 1)
) (
    input  logic          I_RD_CLK,
    input  logic          I_RD_RST_N,
    input  logic          I_RD_EMPTY,
    output logic          O_RD_EN,
    input  logic [DW-1:0] I_RD_DATA,
    input  logic          I_RD_FLUSH,
    output logic          O_M_VALID,
    input  logic          I_M_READY,
    output logic [DW-1:0] O_M_DATA,
    output logic [LW-1:0] O_M_LEVEL
);

    localparam int PW = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    // Occupancy can transiently count level plus every in-flight flag.
    localparam int OW = $clog2(BUF_D + RL + 1) + 1;

    // Pointer increment with wrap at BUF_D (need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_D - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                    r_run_q;
    logic [RL-1:0]           vld_pipe_q, vld_pipe_d;
    logic [LW-1:0]           level_q, level_d;
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic [BUF_D-1:0][DW-1:0] mem_q;

    logic [OW-1:0] inflight;
    logic [OW-1:0] occ;
    logic          pop;
    logic          cap;
    logic          rd_en;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RL; i++) begin
            inflight = inflight + OW'(vld_pipe_q[i]);
        end
        occ = OW'(level_q) + inflight;
        pop = (level_q != '0) & I_M_READY;
        // Oldest issue flag: RAM data for it is on I_RD_DATA this cycle.
        cap = vld_pipe_q[RL-1];
        // Issue only if the word will have a slot when it lands, counting
        // the slot freed by a pop on this same edge.
        rd_en = r_run_q & ~I_RD_EMPTY & ~I_RD_FLUSH
              & ((occ - OW'(pop)) < OW'(BUF_D));
    end

    always_comb begin
        vld_pipe_d = RL'({vld_pipe_q, rd_en});
        level_d    = level_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (I_RD_FLUSH) begin
            // Returning data for anything issued before the flush is dropped.
            vld_pipe_d = '0;
            level_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (cap) tail_d = ptr_inc(tail_q);
            if (pop) head_d = ptr_inc(head_q);
            if (cap && !pop)      level_d = level_q + LW'(1);
            else if (!cap && pop) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge I_RD_CLK or negedge I_RD_RST_N) begin
        if (!I_RD_RST_N) begin
            // Empty reads 0 during reset, so reads stay blocked until the
            // first edge after release.
            r_run_q    <= 1'b0;
            vld_pipe_q <= '0;
            level_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            mem_q      <= '0;
        end else begin
            r_run_q    <= 1'b1;
            vld_pipe_q <= vld_pipe_d;
            level_q    <= level_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (cap && !I_RD_FLUSH) mem_q[tail_q] <= I_RD_DATA;
        end
    end

    assign O_RD_EN   = rd_en;
    assign O_M_VALID = (level_q != '0);
    assign O_M_DATA  = mem_q[head_q];
    assign O_M_LEVEL = level_q;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: instance A (RL=1, BUF_D=2) and B (RL=2, BUF_D=3),
// each fed by a simple FIFO + RAM-latency model.
module tb_fifo_rd_fwft;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic ready = 1'b0;

    int total = 0;
    int bad   = 0;

    // ---- instance A model: RL=1 ----
    logic [7:0] amem [0:255];
    int         a_wp = 0;
    int         a_rp = 0;
    logic [7:0] a_d1 = '0;
    logic       a_empty, a_rd_en, a_valid;
    logic [7:0] a_data;
    logic [1:0] a_level;
    assign a_empty = (a_wp == a_rp);
    always @(posedge clk) begin
        if (a_rd_en) begin
            a_d1 <= amem[a_rp[7:0]];
            a_rp <= a_rp + 1;
        end
    end

    // ---- instance B model: RL=2 ----
    logic [7:0] bmem [0:255];
    int         b_wp = 0;
    int         b_rp = 0;
    logic [7:0] b_d1 = '0;
    logic [7:0] b_d2 = '0;
    logic       b_empty, b_rd_en, b_valid;
    logic [7:0] b_data;
    logic [1:0] b_level;
    assign b_empty = (b_wp == b_rp);
    always @(posedge clk) begin
        if (b_rd_en) begin
            b_d1 <= bmem[b_rp[7:0]];
            b_rp <= b_rp + 1;
        end
        b_d2 <= b_d1;
    end

    fifo_rd_fwft #(.DW(8), .RL(1), .BUF_D(2)) u_a (
        .I_RD_CLK(clk), .I_RD_RST_N(rst_n), .I_RD_EMPTY(a_empty), .O_RD_EN(a_rd_en),
        .I_RD_DATA(a_d1), .I_RD_FLUSH(flush), .O_M_VALID(a_valid), .I_M_READY(ready),
        .O_M_DATA(a_data), .O_M_LEVEL(a_level)
    );

    fifo_rd_fwft #(.DW(8), .RL(2), .BUF_D(3)) u_b (
        .I_RD_CLK(clk), .I_RD_RST_N(rst_n), .I_RD_EMPTY(b_empty), .O_RD_EN(b_rd_en),
        .I_RD_DATA(b_d2), .I_RD_FLUSH(flush), .O_M_VALID(b_valid), .I_M_READY(ready),
        .O_M_DATA(b_data), .O_M_LEVEL(b_level)
    );

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; ready = 1'b0;
        amem[a_wp[7:0]] = 8'h5A; a_wp = a_wp + 1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (a_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b exp=0", a_rd_en); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", a_valid); end
        total++; if (a_level !== 2'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", a_level); end
        total++; if (a_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", a_data); end
        total++; if (b_valid !== 1'b0 || b_level !== 2'd0) begin bad++; $display("FAIL rst_b got=%b/%0d exp=0/0", b_valid, b_level); end
        @(negedge clk); rst_n = 1'b1; #1;
        total++; if (a_rd_en !== 1'b0) begin bad++; $display("FAIL rel_rd_en got=%b exp=0", a_rd_en); end
        @(negedge clk); #1;
        total++; if (a_rd_en !== 1'b1) begin bad++; $display("FAIL run_rd_en got=%b exp=1", a_rd_en); end
        @(negedge clk); #1;
        total++; if (a_rd_en !== 1'b0 || a_valid !== 1'b0) begin bad++; $display("FAIL rst_t1 got=%b/%b exp=0/0", a_rd_en, a_valid); end
        @(negedge clk); #1;
        total++; if (a_valid !== 1'b1 || a_data !== 8'h5A) begin bad++; $display("FAIL rst_t2 got=%b/%h exp=1/5a", a_valid, a_data); end
        @(negedge clk); ready = 1'b1; #1;
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL rst_pop got=%b exp=1", a_valid); end
        @(negedge clk); ready = 1'b0; #1;
        total++; if (a_valid !== 1'b0 || a_level !== 2'd0) begin bad++; $display("FAIL rst_drain got=%b/%0d exp=0/0", a_valid, a_level); end
    endtask

    task automatic test_single();
        @(negedge clk); ready = 1'b0;
        amem[a_wp[7:0]] = 8'hA5; a_wp = a_wp + 1;
        #1;
        total++; if (a_rd_en !== 1'b1) begin bad++; $display("FAIL one_issue got=%b exp=1", a_rd_en); end
        @(negedge clk); #1;
        total++; if (a_rd_en !== 1'b0 || a_valid !== 1'b0) begin bad++; $display("FAIL one_t1 got=%b/%b exp=0/0", a_rd_en, a_valid); end
        @(negedge clk); #1;
        total++; if (a_valid !== 1'b1 || a_data !== 8'hA5) begin bad++; $display("FAIL one_t2 got=%b/%h exp=1/a5", a_valid, a_data); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            total++;
            if (a_valid !== 1'b1 || a_data !== 8'hA5 || a_rd_en !== 1'b0 || a_level !== 2'd1) begin
                bad++; $display("FAIL one_hold[%0d] got=%b/%h/%b/%0d exp=1/a5/0/1", i, a_valid, a_data, a_rd_en, a_level);
            end
        end
        @(negedge clk); ready = 1'b1; #1;
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL one_pop got=%b exp=1", a_valid); end
        @(negedge clk); #1;
        total++; if (a_valid !== 1'b0 || a_level !== 2'd0 || a_rd_en !== 1'b0) begin bad++; $display("FAIL one_done got=%b/%0d/%b exp=0/0/0", a_valid, a_level, a_rd_en); end
        repeat (3) @(negedge clk); #1;
        total++; if (a_rd_en !== 1'b0) begin bad++; $display("FAIL one_idle got=%b exp=0", a_rd_en); end
    endtask

    task automatic test_stream();
        int first_en = -1;
        int first_v  = -1;
        int n        = 0;
        @(negedge clk); ready = 1'b1;
        for (int v = 0; v < 16; v++) begin amem[a_wp[7:0]] = 8'(v); a_wp = a_wp + 1; end
        for (int c = 0; c < 60 && n < 16; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (a_rd_en && first_en < 0) first_en = c;
            if (a_valid) begin
                if (first_v < 0) first_v = c;
                total++;
                if (a_data !== 8'(n) || c != first_v + n) begin
                    bad++; $display("FAIL stream[%0d] got=%h@%0d exp=%h@%0d", n, a_data, c, 8'(n), first_v + n);
                end
                n++;
            end
        end
        total++; if (first_en != 0) begin bad++; $display("FAIL stream_first_en got=%0d exp=0", first_en); end
        total++; if (first_v != first_en + 2) begin bad++; $display("FAIL stream_latency got=%0d exp=%0d", first_v, first_en + 2); end
        total++; if (n != 16) begin bad++; $display("FAIL stream_count got=%0d exp=16", n); end
    endtask

    task automatic test_random();
        int         n       = 0;
        int         loaded  = 0;
        logic       pv      = 1'b0;
        logic       pr      = 1'b0;
        logic [7:0] pd      = '0;
        logic       prev_en = 1'b0;
        for (int c = 0; c < 400 && n < 16; c++) begin
            @(negedge clk);
            if (loaded < 16 && (c % 3) == 0) begin
                amem[a_wp[7:0]] = 8'(loaded); a_wp = a_wp + 1; loaded++;
            end
            ready = ($urandom_range(0, 1) == 1);
            #1;
            total++; if (a_rd_en && a_empty) begin bad++; $display("FAIL rnd_en_empty c=%0d got=1 exp=0", c); end
            total++; if (a_level > 2'd2) begin bad++; $display("FAIL rnd_level got=%0d exp<=2", a_level); end
            total++; if (int'(a_level) + int'(prev_en) > 2) begin bad++; $display("FAIL rnd_occ got=%0d exp<=2", int'(a_level) + int'(prev_en)); end
            if (pv && !pr) begin
                total++;
                if (a_valid !== 1'b1 || a_data !== pd) begin bad++; $display("FAIL rnd_stall got=%b/%h exp=1/%h", a_valid, a_data, pd); end
            end
            if (a_valid && ready) begin
                total++;
                if (a_data !== 8'(n)) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", n, a_data, 8'(n)); end
                n++;
            end
            pv = a_valid; pr = ready; pd = a_data; prev_en = a_rd_en;
        end
        total++; if (n != 16) begin bad++; $display("FAIL rnd_count got=%0d exp=16", n); end
    endtask

    task automatic test_flush();
        int         n        = 0;
        int         first_en = -1;
        int         fc       = -1;
        logic [7:0] exp_d;
        @(negedge clk); ready = 1'b1;
        for (int v = 0; v < 16; v++) begin amem[a_wp[7:0]] = 8'(v); a_wp = a_wp + 1; end
        for (int c = 0; c < 80 && n < 15; c++) begin
            if (c != 0) @(negedge clk);
            flush = (fc >= 0 && c == fc);
            #1;
            if (a_rd_en && first_en < 0) begin first_en = c; fc = c + 6; end
            if (c == fc) begin
                total++; if (a_rd_en !== 1'b0) begin bad++; $display("FAIL fl_rd_en got=%b exp=0", a_rd_en); end
            end
            if (fc >= 0 && c == fc + 1) begin
                total++; if (a_valid !== 1'b0 || a_level !== 2'd0) begin bad++; $display("FAIL fl_clear got=%b/%0d exp=0/0", a_valid, a_level); end
            end
            if (fc >= 0 && c == fc + 3) begin
                total++; if (a_valid !== 1'b1 || a_data !== 8'h06) begin bad++; $display("FAIL fl_resume got=%b/%h exp=1/06", a_valid, a_data); end
            end
            if (a_valid && ready) begin
                // Word 5 was in flight at the flush and must never appear.
                exp_d = (n < 5) ? 8'(n) : 8'(n + 1);
                total++;
                if (a_data !== exp_d) begin bad++; $display("FAIL fl_data[%0d] got=%h exp=%h", n, a_data, exp_d); end
                n++;
            end
        end
        flush = 1'b0;
        total++; if (n != 15) begin bad++; $display("FAIL fl_count got=%0d exp=15", n); end
    endtask

    task automatic test_rl2();
        int first_en = -1;
        int first_v  = -1;
        int n        = 0;
        @(negedge clk); ready = 1'b1;
        for (int v = 0; v < 32; v++) begin bmem[b_wp[7:0]] = 8'(v); b_wp = b_wp + 1; end
        for (int c = 0; c < 100 && n < 20; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (b_rd_en && first_en < 0) first_en = c;
            total++; if (b_level > 2'd3) begin bad++; $display("FAIL rl2_level got=%0d exp<=3", b_level); end
            if (b_valid) begin
                if (first_v < 0) first_v = c;
                total++;
                if (b_data !== 8'(n) || c != first_v + n) begin
                    bad++; $display("FAIL rl2[%0d] got=%h@%0d exp=%h@%0d", n, b_data, c, 8'(n), first_v + n);
                end
                n++;
            end
        end
        total++; if (first_en != 0) begin bad++; $display("FAIL rl2_first_en got=%0d exp=0", first_en); end
        total++; if (first_v != first_en + 3) begin bad++; $display("FAIL rl2_latency got=%0d exp=%0d", first_v, first_en + 3); end
        total++; if (n != 20) begin bad++; $display("FAIL rl2_count got=%0d exp=20", n); end
        // Mid-stream reset: outputs clear asynchronously.
        @(negedge clk); rst_n = 1'b0; #1;
        total++; if (b_valid !== 1'b0 || b_level !== 2'd0) begin bad++; $display("FAIL rl2_rst got=%b/%0d exp=0/0", b_valid, b_level); end
        total++; if (b_data !== 8'h00 || b_rd_en !== 1'b0) begin bad++; $display("FAIL rl2_rst_out got=%h/%b exp=00/0", b_data, b_rd_en); end
        @(negedge clk); rst_n = 1'b1; #1;
        total++; if (b_rd_en !== 1'b0) begin bad++; $display("FAIL rl2_rel got=%b exp=0", b_rd_en); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_random();
        test_flush();
        test_rl2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
